// File: rtl/rr_enc_pkg.sv
// Shared definitions for the round-robin encoder: default width, index-width
// helper and circular rotations of a request vector.
package rr_enc_pkg;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned MAX_N     = 64;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_N-1:0] low_mask(input int unsigned n);
    return (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
  endfunction

  // Rotations act on the low n bits only; bits above n are cleared.
  function automatic logic [MAX_N-1:0] rotr(input logic [MAX_N-1:0] v,
                                            input int unsigned     sh,
                                            input int unsigned     n);
    logic [MAX_N-1:0] vm;
    int unsigned      s;
    vm = v & low_mask(n);
    s  = sh % n;
    if (s == 0) return vm;
    return ((vm >> s) | (vm << (n - s))) & low_mask(n);
  endfunction

  function automatic logic [MAX_N-1:0] rotl(input logic [MAX_N-1:0] v,
                                            input int unsigned     sh,
                                            input int unsigned     n);
    return rotr(v, n - (sh % n), n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational fixed-priority find-first: lowest set bit wins.
module rr_pick
  import rr_enc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_encoder_8to3.sv
// Registered round-robin encoder with valid/ready output.
// Define RR_ENCODER_MULTIHOT_EN to add the out_multi flag.
module rr_encoder_8to3
  import rr_enc_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
`ifdef RR_ENCODER_MULTIHOT_EN
  output logic             out_multi,
`endif
  output logic [IDX_W-1:0] out_index
);

  logic             hs;
  logic             cap;
  logic             found;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] offset;
  logic [IDX_W-1:0] sel;
  logic [N-1:0]     rot;

  // N is a power of two, so IDX_W-bit arithmetic wraps modulo N for free.
  assign hs       = out_valid & out_ready;
  assign next_idx = out_index + IDX_W'(1);
  assign start    = hs ? next_idx : ptr;
  assign rot      = N'(rotr(MAX_N'(req), 32'(start), N));
  assign sel      = start + offset;
  assign cap      = enable & found & (~out_valid | out_ready);

  rr_pick #(.N(N)) u_pick (
    .vec   (rot),
    .idx   (offset),
    .found (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
      ptr       <= '0;
    end else begin
      if (hs) ptr <= next_idx;
      if (cap) begin
        out_valid <= 1'b1;
        out_index <= sel;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_ENCODER_MULTIHOT_EN
  logic multi;
  assign multi = (req & (req - N'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst)      out_multi <= 1'b0;
    else if (cap) out_multi <= multi;
  end
`endif

endmodule

// File: tb/tb_rr_encoder_8to3.sv
// Self-checking bench for rr_encoder_8to3: directed scenarios plus randomized
// traffic against a circular-scan reference model.
module tb_rr_encoder_8to3;

  localparam int N = 8;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_index;
`ifdef RR_ENCODER_MULTIHOT_EN
  logic       out_multi;
`endif

  int checks;
  int failures;

  int m_vld;
  int m_idx;
  int m_ptr;
  int m_multi;

  rr_encoder_8to3 #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
`ifdef RR_ENCODER_MULTIHOT_EN
    .out_multi (out_multi),
`endif
    .out_index (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic [7:0] q, input logic rd);
    int hs;
    int cap;
    int start;
    rst = r; enable = e; req = q; out_ready = rd;
    @(posedge clk);
    if (r) begin
      m_vld = 0; m_idx = 0; m_ptr = 0; m_multi = 0;
    end else begin
      hs    = (m_vld != 0 && rd) ? 1 : 0;
      cap   = (e && q != 0 && (m_vld == 0 || rd)) ? 1 : 0;
      start = hs ? (m_idx + 1) % N : m_ptr;
      if (hs) m_ptr = (m_idx + 1) % N;
      if (cap) begin
        m_idx   = first_from(q, start);
        m_vld   = 1;
        m_multi = ($countones(q) >= 2) ? 1 : 0;
      end else if (hs) begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_index !== 3'd0) begin
      failures++;
      $display("FAIL reset: got valid=%b idx=%0d, want valid=0 idx=0", out_valid, out_index);
    end
`ifdef RR_ENCODER_MULTIHOT_EN
    checks++;
    if (out_multi !== 1'b0) begin
      failures++;
      $display("FAIL reset_multi: got %b, want 0", out_multi);
    end
`endif
  endtask

  task automatic test_alternate;
    int exp_seq [4] = '{0, 2, 0, 2};
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'b0000_0101, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'(exp_seq[i])) begin
        failures++;
        $display("FAIL alternate[%0d]: got valid=%b idx=%0d, want valid=1 idx=%0d",
                 i, out_valid, out_index, exp_seq[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int exp_seq [4] = '{0, 7, 0, 7};
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'b1000_0001, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'(exp_seq[i])) begin
        failures++;
        $display("FAIL wrap[%0d]: got valid=%b idx=%0d, want valid=1 idx=%0d",
                 i, out_valid, out_index, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h04, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'hF0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 3'd2) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b idx=%0d, want valid=1 idx=2",
                 i, out_valid, out_index);
      end
    end
    cycle(1'b0, 1'b1, 8'hF0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd4) begin
      failures++;
      $display("FAIL backpressure_release: got valid=%b idx=%0d, want valid=1 idx=4",
               out_valid, out_index);
    end
  endtask

  task automatic test_enable_off;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'hFF, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL enable_off[%0d]: got valid=%b, want 0", i, out_valid);
      end
    end
    cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd0) begin
      failures++;
      $display("FAIL enable_on: got valid=%b idx=%0d, want valid=1 idx=0", out_valid, out_index);
    end
  endtask

  task automatic test_empty_req;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h20, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd5) begin
      failures++;
      $display("FAIL empty_setup: got valid=%b idx=%0d, want valid=1 idx=5", out_valid, out_index);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_index !== 3'd5) begin
      failures++;
      $display("FAIL empty_drop: got valid=%b idx=%0d, want valid=0 idx=5", out_valid, out_index);
    end
    cycle(1'b0, 1'b1, 8'b0010_0001, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd0) begin
      failures++;
      $display("FAIL empty_ptr_wrap: got valid=%b idx=%0d, want valid=1 idx=0", out_valid, out_index);
    end
  endtask

  task automatic test_mid_reset;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h08, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd3) begin
      failures++;
      $display("FAIL midrst_setup: got valid=%b idx=%0d, want valid=1 idx=3", out_valid, out_index);
    end
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_index !== 3'd0) begin
      failures++;
      $display("FAIL midrst_clear: got valid=%b idx=%0d, want valid=0 idx=0", out_valid, out_index);
    end
    cycle(1'b0, 1'b1, 8'b0000_1010, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd1) begin
      failures++;
      $display("FAIL midrst_ptr: got valid=%b idx=%0d, want valid=1 idx=1", out_valid, out_index);
    end
`ifdef RR_ENCODER_MULTIHOT_EN
    checks++;
    if (out_multi !== 1'b1) begin
      failures++;
      $display("FAIL midrst_multi: got %b, want 1", out_multi);
    end
`endif
  endtask

  task automatic test_random;
    logic [7:0] q;
    logic       e;
    logic       rd;
    logic       r;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 400; i++) begin
      q  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      e  = ($urandom_range(0, 4) != 0);
      rd = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 49) == 0);
      cycle(r, e, q, rd);
      checks++;
      if (out_valid !== 1'(m_vld) || out_index !== 3'(m_idx)) begin
        failures++;
        $display("FAIL random[%0d]: got valid=%b idx=%0d, want valid=%0d idx=%0d",
                 i, out_valid, out_index, m_vld, m_idx);
      end
`ifdef RR_ENCODER_MULTIHOT_EN
      checks++;
      if (out_multi !== 1'(m_multi)) begin
        failures++;
        $display("FAIL random_multi[%0d]: got %b, want %0d", i, out_multi, m_multi);
      end
`endif
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_vld = 0; m_idx = 0; m_ptr = 0; m_multi = 0;
    rst = 1'b1; enable = 1'b0; req = 8'h00; out_ready = 1'b0;
    test_reset;
    test_alternate;
    test_wrap;
    test_backpressure;
    test_enable_off;
    test_empty_req;
    test_mid_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
